// File: rtl/fpu_mult_arb.sv
// Round-robin arbiter sharing one fpu_mult between the issue path (port 0)
// and the divide/sqrt sequencer (port 1); one operation in flight at a time.
module fpu_mult_arb #(
   parameter int TAG_W      = 5,
   parameter int MAX_CYCLES = 52
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [31:0]      req0_opa,
   input  logic [31:0]      req0_opb,
   input  logic [31:0]      req1_opa,
   input  logic [31:0]      req1_opb,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [31:0]      mul_opa,
   output logic [31:0]      mul_opb,
   output logic             mul_start,
   input  logic             mul_busy,
   input  logic [34:0]      mul_out,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [TAG_W-1:0] resp_tag,
   output logic [34:0]      resp_data,
   output logic             resp_err
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   localparam logic [5:0] CNT_LAST = 6'(MAX_CYCLES - 1);
   localparam logic [5:0] CNT_SAT  = 6'h3F;

   state_t     state, state_nxt;
   logic       rr_last;
   logic [5:0] wait_cnt;
   logic [1:0] grant;
   logic       wait_done;

   // Leave WAIT on normalisation done or on watchdog expiry.
   assign wait_done = !mul_busy || (wait_cnt == CNT_LAST);

   always_comb begin
      grant     = 2'b00;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!flush) begin
               unique case (req_valid)
                  2'b01:   grant = 2'b01;
                  2'b10:   grant = 2'b10;
                  2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                  default: grant = 2'b00;
               endcase
               if (grant != 2'b00) state_nxt = START;
            end
         end
         START: state_nxt = WAIT;
         WAIT:  if (wait_done) state_nxt = RESP;
         RESP:  if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush && state != IDLE) state_nxt = IDLE;
   end

   assign req_ready  = rst ? 2'b00 : grant;
   assign mul_start  = (state == START);
   // A flushed response must never be seen, even in the cycle flush arrives.
   assign resp_valid = (state == RESP) && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_last   <= 1'b1;
         wait_cnt  <= 6'd0;
         mul_opa   <= 32'd0;
         mul_opb   <= 32'd0;
         resp_id   <= 1'b0;
         resp_tag  <= '0;
         resp_data <= 35'd0;
         resp_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  mul_opa  <= grant[1] ? req1_opa : req0_opa;
                  mul_opb  <= grant[1] ? req1_opb : req0_opb;
                  resp_tag <= grant[1] ? req1_tag : req0_tag;
                  resp_id  <= grant[1];
               end
            end
            START: wait_cnt <= 6'd0;
            WAIT: begin
               if (wait_cnt != CNT_SAT) wait_cnt <= wait_cnt + 6'd1;
               if (!flush && wait_done) begin
                  resp_data <= mul_out;
                  resp_err  <= mul_busy;
               end
            end
            RESP: if (resp_ready && !flush) rr_last <= resp_id;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_mult_arb.sv
// Randomized bench for fpu_mult_arb with a behavioural multiplier stub and
// a transaction-level arbitration/latency reference model.
module tb_fpu_mult_arb;

   localparam int TAG_W      = 5;
   localparam int MAX_CYCLES = 52;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [31:0]      req0_opa, req0_opb, req1_opa, req1_opb;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic [31:0]      mul_opa, mul_opb;
   logic             mul_start;
   logic             mul_busy;
   logic [34:0]      mul_out = 35'd0;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [TAG_W-1:0] resp_tag;
   logic [34:0]      resp_data;
   logic             resp_err;

   int n_cmp = 0;
   int n_bad = 0;
   int stub_delay = 0;
   bit stub_hang = 1'b0;
   int bcnt = 0;
   bit mrr = 1'b1;

   fpu_mult_arb #(.TAG_W(TAG_W), .MAX_CYCLES(MAX_CYCLES)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_opa(req0_opa), .req0_opb(req0_opb),
      .req1_opa(req1_opa), .req1_opb(req1_opb),
      .req0_tag(req0_tag), .req1_tag(req1_tag),
      .mul_opa(mul_opa), .mul_opb(mul_opb), .mul_start(mul_start),
      .mul_busy(mul_busy), .mul_out(mul_out),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_tag(resp_tag),
      .resp_data(resp_data), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // IEEE single product in {sign, exp, mant23, g, r, s} form, overflow ignored.
   function automatic logic [34:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [23:0] ma, mb;
      int e;
      logic s;
      s = a[31] ^ b[31];
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 34'd0};
      ma = {1'b1, a[22:0]};
      mb = {1'b1, b[22:0]};
      p = 48'(ma) * 48'(mb);
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) return {s, 8'(e + 1), p[46:24], p[23], p[22], |p[21:0]};
      return {s, 8'(e), p[45:23], p[22], p[21], |p[20:0]};
   endfunction

   function automatic logic [31:0] rnd_fp();
      if ($urandom_range(0, 7) == 0) return 32'd0;
      return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
   endfunction

   // Multiplier stub: result appears at start, busy for stub_delay cycles.
   always @(posedge clk) begin
      if (mul_start) begin
         mul_out <= fmul_ref(mul_opa, mul_opb);
         bcnt    <= stub_delay;
      end else if (bcnt > 0) begin
         bcnt <= bcnt - 1;
      end
   end
   assign mul_busy = stub_hang || (bcnt != 0);

   always @(negedge clk) check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);

   task automatic run_op(input logic [1:0] v,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                         input int dly, input int bp, input bit hold_v, input bit hang);
      int win, n, exp_n;
      logic [31:0] ea, eb;
      logic [TAG_W-1:0] et;
      logic [34:0] ed;
      logic [1:0] er;
      bit eerr;
      win   = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : (mrr ? 0 : 1);
      ea    = win ? a1 : a0;
      eb    = win ? b1 : b0;
      et    = win ? t1 : t0;
      ed    = fmul_ref(ea, eb);
      er    = win ? 2'b10 : 2'b01;
      eerr  = hang || (dly >= MAX_CYCLES);
      exp_n = eerr ? MAX_CYCLES + 2 : dly + 3;
      stub_delay = dly;
      stub_hang  = hang;
      @(negedge clk);
      req_valid = v;
      req0_opa = a0; req0_opb = b0; req1_opa = a1; req1_opb = b1;
      req0_tag = t0; req1_tag = t1;
      #1;
      check("grant", 64'(req_ready), 64'(er));
      @(negedge clk);
      if (!hold_v) req_valid = 2'b00;
      #1;
      check("start", 64'({mul_start, req_ready}), 64'({1'b1, 2'b00}));
      check("operands", {mul_opa, mul_opb}, {ea, eb});
      n = 1;
      while (!resp_valid && n < MAX_CYCLES + 8) begin
         @(negedge clk);
         #1;
         n++;
         if (n == 2) check("start_pulse", 64'(mul_start), 64'd0);
      end
      check("latency", 64'(n), 64'(exp_n));
      check("resp_data", 64'(resp_data), 64'(ed));
      check("resp_meta", 64'({resp_valid, resp_id, resp_tag, resp_err}),
            64'({1'b1, 1'(win), et, eerr}));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         #1;
         check("hold", 64'({resp_valid, resp_id, resp_err, resp_tag, resp_data, req_ready}),
               64'({1'b1, 1'(win), eerr, et, ed, 2'b00}));
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      stub_hang  = 1'b0;
      mrr = 1'(win);
      check("drop", 64'(resp_valid), 64'd0);
   endtask

   initial begin
      logic [1:0] v;
      rst = 1'b1; flush = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
      req0_opa = 32'd0; req0_opb = 32'd0; req1_opa = 32'd0; req1_opb = 32'd0;
      req0_tag = '0; req1_tag = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ctrl", 64'({req_ready, mul_start, resp_valid, resp_err, resp_id, resp_tag}), 64'd0);
      check("rst_data", 64'(resp_data), 64'd0);
      check("rst_ops", {mul_opa, mul_opb}, 64'd0);
      rst = 1'b0;

      run_op(2'b01, 32'h3F800000, 32'h3F800000, 32'd0, 32'd0, 5'd3, 5'd0, 0, 0, 1'b0, 1'b0);
      check("tp_one", 64'({resp_id, resp_tag, resp_data}), 64'({1'b0, 5'd3, 35'h1FC000000}));
      run_op(2'b10, 32'd0, 32'd0, 32'h40000000, 32'h40400000, 5'd0, 5'd7, 1, 0, 1'b0, 1'b0);
      check("tp_six", 64'({resp_id, resp_tag, resp_data}), 64'({1'b1, 5'd7, 35'h206000000}));

      for (int i = 0; i < 4; i++) begin
         run_op(2'b11, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), 5'($urandom), 5'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1, 1'b0);
         check("cont_order", 64'(resp_id), 64'(i % 2));
      end

      run_op(2'b01, 32'd0, 32'h3F800000, 32'd0, 32'd0, 5'd1, 5'd0, 0, 0, 1'b0, 1'b0);
      check("tp_zero", 64'(resp_data), 64'd0);

      run_op(2'b11, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), 5'd12, 5'd21, 2, 10, 1'b1, 1'b0);
      run_op(2'b01, rnd_fp(), rnd_fp(), 32'd0, 32'd0, 5'd30, 5'd0, 0, 1, 1'b0, 1'b1);

      // Flush while the multiplier is still busy.
      @(negedge clk);
      req_valid = 2'b01; req0_opa = 32'h3F800000; req0_opb = 32'h40000000; stub_delay = 10;
      #1;
      check("fl_grant", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("fl_wait", 64'(resp_valid), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      req_valid = 2'b11;
      #1;
      check("fl_rr", 64'(req_ready), mrr ? 64'd1 : 64'd2);
      req_valid = 2'b00;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         check("fl_quiet", 64'({resp_valid, mul_start}), 64'd0);
      end

      // Flush in IDLE suppresses the grant.
      @(negedge clk);
      req_valid = 2'b01; flush = 1'b1;
      #1;
      check("fl_idle", 64'(req_ready), 64'd0);
      @(negedge clk);
      req_valid = 2'b00; flush = 1'b0;
      #1;
      check("fl_nostart", 64'(mul_start), 64'd0);

      for (int i = 0; i < 10; i++) begin
         v = 2'($urandom_range(1, 3));
         run_op(v, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), 5'($urandom), 5'($urandom),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset while a response is pending.
      @(negedge clk);
      req_valid = 2'b10; req1_opa = 32'h40000000; req1_opb = 32'h40400000; req1_tag = 5'd9;
      stub_delay = 0;
      @(negedge clk);
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      #1;
      check("rr_resp", 64'({resp_valid, resp_tag}), 64'({1'b1, 5'd9}));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mrr = 1'b1;
      check("rr_ctrl", 64'({req_ready, mul_start, resp_valid, resp_err, resp_id, resp_tag}), 64'd0);
      check("rr_data", 64'(resp_data), 64'd0);
      check("rr_ops", {mul_opa, mul_opb}, 64'd0);
      run_op(2'b11, rnd_fp(), rnd_fp(), rnd_fp(), rnd_fp(), 5'd4, 5'd5, 1, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fpu_mult_arb.md
Name: fpu_mult_arb

Overview:
- Shares one fpu_mult instance (and its 24x24 mantissa multiplier) between two requesters: port 0 is the integer/FP issue path, port 1 is the FP divide/sqrt micro-sequencer.
- Arbitrates round-robin and latches the winner's operands.
- Pulses the multiplier start, waits for normalisation to finish, then holds the 35-bit result with id/tag until the consumer accepts it.
- Sits in ex_stage between the issue logic and the FPU datapath.

Parameters:
- TAG_W, 5, width of the opaque tag carried from request to response.
- MAX_CYCLES, 52, watchdog limit on WAIT-state cycles before forced completion with error.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of the in-flight operation; no response is produced.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req0_opa, req0_opb  in  32  requester 0 IEEE-754 single operands.
- req1_opa, req1_opb  in  32  requester 1 operands.
- req0_tag, req1_tag  in  TAG_W  requester tags.
- mul_opa, mul_opb  out  32  operands to the multiplier and flag decode.
- mul_start  out  1  one-cycle new_input pulse to the multiplier.
- mul_busy  in  1  multiplier busy.
- mul_out  in  35  multiplier result {sign, exp, 23-bit mantissa, guard, round, sticky}.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accept.
- resp_id  out  1  requester index that owns the result.
- resp_tag  out  TAG_W  tag of the owning request.
- resp_data  out  35  captured mul_out.
- resp_err  out  1  watchdog expired; resp_data is still whatever mul_out held.

Behaviour:
- States: IDLE, START, WAIT, RESP. Reset state is IDLE.
- Reset values: req_ready=0, mul_start=0, resp_valid=0, resp_err=0, resp_data=0, resp_id=0, resp_tag=0, mul_opa=0, mul_opb=0, wait counter=0, rr_last=1 (so requester 0 wins first).
- IDLE:
  - req_ready is combinational from req_valid and rr_last.
  - One valid requester: it is granted.
  - Both valid: the requester != rr_last is granted.
  - Grant cycle: req_ready[winner]=1; opa, opb, tag and id are latched; next state START.
  - No valid requester: stay in IDLE.
- req_ready is 0 in every state other than IDLE.
- START: mul_start=1 for exactly this cycle; mul_opa/mul_opb are driven from the latch, stable from START through WAIT; counter cleared; next state WAIT.
- WAIT:
  - Each cycle, counter is incremented.
  - mul_busy=0: capture mul_out into resp_data, resp_err=0, next state RESP.
  - Otherwise, if counter==MAX_CYCLES-1: capture mul_out, resp_err=1, next state RESP.
  - mul_busy is ignored during START.
- RESP: resp_valid=1 and resp_data/id/tag/err are held stable. When resp_ready=1: rr_last <= resp_id, resp_valid drops next cycle, next state IDLE.
- Latency:
  - Grant in cycle T, START at T+1, first WAIT at T+2.
  - Minimum resp_valid is T+3 (product MSB already set, or special-case input).
  - Each normalisation shift adds one cycle.
- Throughput: at most one operation in flight. The next grant happens no earlier than the cycle after the RESP handshake.
- flush:
  - In START/WAIT/RESP: next state IDLE, resp_valid=0, rr_last unchanged, no response.
  - In IDLE: suppresses the grant that cycle (req_ready=0).
  - The multiplier is not reset. A later mul_start reloads it.
- rst beats flush. A mid-operation rst returns every register to its reset value the next cycle.
- Width rules: the counter is 6 bits wide (MAX_CYCLES ≤ 63) and saturates. Tags pass through unmodified.

Test Plan:
- Single request, normal operands: req0 opa=0x3F800000, opb=0x3F800000, tag=3 -> grant T, mul_start at T+1, resp_valid with resp_data=35'h1FC000000, id=0, tag=3.
- Second value check: req1 opa=0x40000000, opb=0x40400000, tag=7 -> resp_data=35'h206000000, id=1, tag=7.
- Contention: both valid continuously for 4 operations -> grant order 0,1,0,1, each grant only after the prior handshake, and req_ready never two-hot.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP -> resp_valid, data, id and tag stay stable, req_ready stays 0; accept, then IDLE grants the next cycle.
- Watchdog: multiplier stub holds mul_busy=1 -> after MAX_CYCLES WAIT cycles, resp_valid=1 with resp_err=1.
- Flush and reset:
  - Flush during WAIT -> no resp_valid, IDLE next cycle, rr_last unchanged.
  - rst asserted in RESP -> all outputs return to their reset values the next cycle.
  - Zero-operand input (opa=0) -> special-case path, resp_data=35'h0 at T+3.
